// File: rtl/dmem_bank_pkg.sv
// Shared types and defaults for the data-memory bank.
// Provides FSM state enum, request bundle, default sizes, byte parity helper.
package dmem_bank_pkg;

   localparam int D_SIZE = 32;
   localparam int D_MEM  = 64;
   localparam int D_ADDR = $clog2(D_MEM);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } dmem_state_t;

   typedef struct packed {
      logic                  we;
      logic [D_ADDR-1:0]     addr;
      logic [D_SIZE/8-1:0]   be;
      logic [D_SIZE-1:0]     wdata;
   } dmem_req_t;

   // Even parity: stored bit makes the 9-bit group hold an even count of ones.
   function automatic logic even_par(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/dmem_bank_array.sv
// Storage for dmem_bank: byte-enable writes, combinational read, optional parity.
// Ports: clk, reset, we/hit/addr/be/wdata (write + range), rdata, perr. Macro: DMEM_PARITY_EN.
module dmem_array
   import dmem_bank_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                we,
   input  logic                hit,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W/8-1:0] be,
   input  logic [DATA_W-1:0]   wdata,
   output logic [DATA_W-1:0]   rdata,
   output logic                perr
);

   localparam int NB = DATA_W / 8;

   logic [DATA_W-1:0] mem [DEPTH];

`ifdef DMEM_PARITY_EN
   logic [NB-1:0] par [DEPTH];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
`ifdef DMEM_PARITY_EN
            par[i] <= '0;
`endif
         end
      end else if (we) begin
         for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
               mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
`ifdef DMEM_PARITY_EN
               par[addr][b] <= even_par(wdata[b*8 +: 8]);
`endif
            end
         end
      end
   end

   // Out-of-range reads return zero rather than whatever the index aliases to.
   assign rdata = hit ? mem[addr] : '0;

`ifdef DMEM_PARITY_EN
   always_comb begin
      perr = 1'b0;
      if (hit) begin
         for (int b = 0; b < NB; b++) begin
            if (par[addr][b] != even_par(mem[addr][b*8 +: 8]))
               perr = 1'b1;
         end
      end
   end
`else
   assign perr = 1'b0;
`endif

endmodule

// File: rtl/dmem_bank.sv
// Mem-stage data memory: valid/ready requests, byte writes, RD_LAT read latency, held response.
// Ports: clk, reset, en, req_* (valid/ready/we/addr/be/wdata), resp_* (valid/ready/rdata/err), parity_err.
// Macro: DMEM_PARITY_EN enables per-byte parity storage and parity_err reporting.
module dmem_bank
   import dmem_bank_pkg::*;
#(
   parameter  int DATA_W = D_SIZE,
   parameter  int DEPTH  = D_MEM,
   parameter  int RD_LAT = 1,
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W/8-1:0] req_be,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_err,
   output logic                parity_err
);

   localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
   localparam logic [2:0]      CNT_INIT = 3'(RD_LAT - 1);

   dmem_state_t       state, state_n;
   logic [2:0]        cnt, cnt_n;
   logic              accept;
   logic              rd_acc;
   logic              hit;
   logic [DATA_W-1:0] arr_rdata;
   logic              arr_perr;

   assign req_ready  = en & (state == IDLE);
   assign accept     = req_valid & req_ready;
   assign rd_acc     = accept & ~req_we;
   assign hit        = {1'b0, req_addr} < DEPTH_C;
   assign resp_valid = (state == RESP);

   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk    (clk),
      .reset  (reset),
      .we     (accept & req_we & hit),
      .hit    (hit),
      .addr   (req_addr),
      .be     (req_be),
      .wdata  (req_wdata),
      .rdata  (arr_rdata),
      .perr   (arr_perr)
   );

   // cnt holds the edges still to go before the response; the accept
   // edge itself counts as the first, so RD_LAT=1 lands directly in RESP.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      unique case (state)
         IDLE: begin
            if (rd_acc) begin
               if (RD_LAT == 1) begin
                  state_n = RESP;
               end else begin
                  state_n = WAIT;
                  cnt_n   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (en) begin
               if (cnt <= 3'd1) begin
                  state_n = RESP;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt - 3'd1;
               end
            end
         end
         RESP: begin
            // Consumer handshake is honoured even while the stage is stalled.
            if (resp_ready)
               state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (rd_acc) begin
            resp_rdata <= arr_rdata;
            resp_err   <= ~hit;
            parity_err <= arr_perr;
         end
      end
   end

endmodule

// File: tb/tb_dmem_bank.sv
// Scoreboard bench for dmem_bank: two instances (64 deep/lat 1, 48 deep/lat 4),
// random + directed traffic checked against an array model in the bench.
module tb_dmem_bank;

   typedef struct {
      logic [31:0] d;
      logic        e;
      logic        p;
      int          acc;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  en, req_valid, req_ready, req_we;
   logic [1:0]  resp_valid, resp_ready, resp_err, parity_err;
   logic [5:0]  req_addr   [2];
   logic [3:0]  req_be     [2];
   logic [31:0] req_wdata  [2];
   logic [31:0] resp_rdata [2];

   logic [31:0] mdl [2][64];
   exp_t        q0[$];
   exp_t        q1[$];
   bit          seen [2];
   int          rr_mode [2];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   dmem_bank #(.DATA_W(32), .DEPTH(64), .RD_LAT(1)) u_d0 (
      .clk(clk), .reset(reset), .en(en[0]),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_addr(req_addr[0]),
      .req_be(req_be[0]), .req_wdata(req_wdata[0]),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
      .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
      .parity_err(parity_err[0])
   );

   dmem_bank #(.DATA_W(32), .DEPTH(48), .RD_LAT(4)) u_d1 (
      .clk(clk), .reset(reset), .en(en[1]),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_addr(req_addr[1]),
      .req_be(req_be[1]), .req_wdata(req_wdata[1]),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
      .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
      .parity_err(parity_err[1])
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int ddep(input int d);
      return (d == 0) ? 64 : 48;
   endfunction

   function automatic int dlat(input int d);
      return (d == 0) ? 1 : 4;
   endfunction

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   function automatic exp_t qfront(input int d);
      return (d == 0) ? q0[0] : q1[0];
   endfunction

   function automatic void qpop(input int d);
      if (d == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
   endfunction

   function automatic void qpush(input int d, input exp_t e);
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
   endfunction

   task automatic chk(input string nm, input int d,
                      input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s dut%0d @cyc %0d: got %h, expected %h",
                  nm, d, cyc, act, want);
      end
   endtask

   // Monitor: compares the head of the scoreboard every cycle a response is shown.
   task automatic mon_step(input int d);
      exp_t e;
      if (reset) begin
         seen[d] = 1'b0;
         if (d == 0) q0.delete();
         else q1.delete();
         return;
      end
      if (!resp_valid[d]) return;
      chk("req_ready_while_resp", d, {31'b0, req_ready[d]}, 32'd0);
      if (qsize(d) == 0) begin
         chk("unexpected_resp_valid", d, {31'b0, resp_valid[d]}, 32'd0);
         return;
      end
      e = qfront(d);
      if (!seen[d]) begin
         seen[d] = 1'b1;
         chk("latency", d, cyc - e.acc, e.lat);
      end
      chk("rdata", d, resp_rdata[d], e.d);
      chk("resp_err", d, {31'b0, resp_err[d]}, {31'b0, e.e});
      chk("parity_err", d, {31'b0, parity_err[d]}, {31'b0, e.p});
      if (resp_ready[d]) begin
         qpop(d);
         seen[d] = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) mon_step(d);
   end

   always @(posedge clk) begin
      #1;
      for (int d = 0; d < 2; d++) begin
         if (rr_mode[d] == 0) resp_ready[d] = 1'($urandom % 2);
         else if (rr_mode[d] == 1) resp_ready[d] = 1'b0;
         else resp_ready[d] = 1'b1;
      end
   end

   // Issue one request; the model is updated when acceptance is certain.
   task automatic do_req(input int d, input bit we, input int addr,
                         input logic [3:0] be, input logic [31:0] wd,
                         input int lat, input bit perr);
      exp_t e;
      int   n = 0;
      req_valid[d] = 1'b1;
      req_we[d]    = we;
      req_addr[d]  = 6'(addr);
      req_be[d]    = be;
      req_wdata[d] = wd;
      forever begin
         @(negedge clk);
         if (req_ready[d]) break;
         n++;
         if (n > 300) begin
            chk("req_ready_timeout", d, {31'b0, req_ready[d]}, 32'd1);
            req_valid[d] = 1'b0;
            return;
         end
      end
      if (we) begin
         if (addr < ddep(d))
            for (int b = 0; b < 4; b++)
               if (be[b]) mdl[d][addr][b*8 +: 8] = wd[b*8 +: 8];
      end else begin
         e.d   = (addr < ddep(d)) ? mdl[d][addr] : 32'd0;
         e.e   = (addr >= ddep(d));
         e.p   = perr;
         e.acc = cyc;
         e.lat = lat;
         qpush(d, e);
      end
      @(posedge clk);
      #1;
      req_valid[d] = 1'b0;
   endtask

   task automatic wait_drain(input int d);
      int n = 0;
      while (qsize(d) != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (qsize(d) != 0)
         chk("drain_timeout", d, 32'(qsize(d)), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int d, a;
      reset      = 1'b1;
      en         = 2'b11;
      req_valid  = 2'b00;
      req_we     = 2'b00;
      resp_ready = 2'b11;
      for (int i = 0; i < 2; i++) begin
         req_addr[i]  = '0;
         req_be[i]    = '0;
         req_wdata[i] = '0;
         rr_mode[i]   = 2;
         for (int j = 0; j < 64; j++) mdl[i][j] = '0;
      end
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_resp_valid", i, {31'b0, resp_valid[i]}, 32'd0);
         chk("rst_rdata", i, resp_rdata[i], 32'd0);
         chk("rst_resp_err", i, {31'b0, resp_err[i]}, 32'd0);
         chk("rst_parity_err", i, {31'b0, parity_err[i]}, 32'd0);
         chk("rst_req_ready", i, {31'b0, req_ready[i]}, 32'd1);
      end
      @(posedge clk);
      #1;

      for (int i = 0; i < 2; i++) begin
         do_req(i, 0, 5, 4'h0, 32'h0, dlat(i), 0);
         do_req(i, 1, 3, 4'hF, 32'hDEADBEEF, 0, 0);
         do_req(i, 1, 3, 4'h2, 32'h00005500, 0, 0);
         do_req(i, 0, 3, 4'h0, 32'h0, dlat(i), 0);
         do_req(i, 1, 4, 4'h0, 32'hFFFFFFFF, 0, 0);
         do_req(i, 0, 4, 4'h0, 32'h0, dlat(i), 0);
         wait_drain(i);
      end

      rr_mode[1] = 1;
      do_req(1, 0, 3, 4'h0, 32'h0, 4, 0);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (resp_valid[1]) break;
         chk("req_ready_in_wait", 1, {31'b0, req_ready[1]}, 32'd0);
      end
      repeat (5) @(posedge clk);
      #1 rr_mode[1] = 2;
      wait_drain(1);

      do_req(1, 1, 50, 4'hF, 32'hCAFEF00D, 0, 0);
      do_req(1, 0, 50, 4'h0, 32'h0, 4, 0);
      do_req(1, 1, 47, 4'hF, 32'h12345678, 0, 0);
      do_req(1, 0, 47, 4'h0, 32'h0, 4, 0);
      wait_drain(1);

      do_req(1, 0, 47, 4'h0, 32'h0, 7, 0);
      en[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1 en[1] = 1'b1;
      wait_drain(1);

      do_req(0, 1, 7, 4'hF, 32'h0BADCAFE, 0, 0);
      do_req(1, 1, 7, 4'hF, 32'h0BADCAFE, 0, 0);
      wait_drain(0);
      do_req(1, 0, 7, 4'h0, 32'h0, 4, 0);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 64; j++) mdl[i][j] = '0;
      @(negedge clk);
      chk("wait_rst_req_ready", 1, {31'b0, req_ready[1]}, 32'd1);
      chk("wait_rst_resp_valid", 1, {31'b0, resp_valid[1]}, 32'd0);
      @(posedge clk);
      #1;
      do_req(0, 0, 7, 4'h0, 32'h0, 1, 0);
      do_req(1, 0, 7, 4'h0, 32'h0, 4, 0);
      do_req(1, 0, 3, 4'h0, 32'h0, 4, 0);
      wait_drain(0);
      wait_drain(1);

`ifdef DMEM_PARITY_EN
      do_req(0, 1, 9, 4'h1, 32'h000000A5, 0, 0);
      @(posedge clk);
      #1;
      u_d0.u_array.mem[9][0] = ~u_d0.u_array.mem[9][0];
      mdl[0][9][0] = ~mdl[0][9][0];
      do_req(0, 0, 9, 4'h0, 32'h0, 1, 1);
      wait_drain(0);
`endif

      rr_mode[0] = 0;
      rr_mode[1] = 0;
      for (int k = 0; k < 300; k++) begin
         d = int'($urandom % 2);
         a = int'($urandom % 64);
         if ($urandom % 2 == 0)
            do_req(d, 1, a, 4'($urandom), $urandom, 0, 0);
         else
            do_req(d, 0, a, 4'h0, 32'h0, dlat(d), 0);
      end
      rr_mode[0] = 2;
      rr_mode[1] = 2;
      wait_drain(0);
      wait_drain(1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
